// File: rtl/dvsd_seqmul_n.sv
// dvsd_seqmul_n: iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One multiplier bit is consumed per CALC cycle, so latency is fixed at WIDTH cycles.
// Signed mode multiplies the operand magnitudes and negates the product when the
// operand signs differ.
module dvsd_seqmul_n #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] m,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [PW-1:0]     a_sh_reg;
  logic [WIDTH-1:0]  b_sh_reg;
  logic [PW-1:0]     acc_reg;
  logic [CW-1:0]     count_reg;
  logic              neg_reg;
  logic [PW-1:0]     m_reg;

  logic              a_neg;
  logic              b_neg;
  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;
  logic [PW-1:0]     addend;
  logic [PW-1:0]     sum;
  logic [PW-1:0]     final_prod;
  logic              last_bit;

  // Operand magnitudes; the WIDTH-bit negate maps the most negative value onto
  // 2^(WIDTH-1), which is still representable as an unsigned magnitude.
  always_comb begin
    a_neg = is_signed & a[WIDTH-1];
    b_neg = is_signed & b[WIDTH-1];
    a_mag = a_neg ? (~a + WIDTH'(1)) : a;
    b_mag = b_neg ? (~b + WIDTH'(1)) : b;
  end

  // Partial product for this cycle: shifted multiplicand gated by the current multiplier bit.
  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_addend
      assign addend[gi] = a_sh_reg[gi] & b_sh_reg[0];
    end
  endgenerate

  assign sum        = acc_reg + addend;
  assign final_prod = neg_reg ? (~sum + PW'(1)) : sum;
  assign last_bit   = (count_reg == LAST);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic: accept only in IDLE, finish after WIDTH CALC cycles, hold DONE until taken.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = CALC;
      CALC:    if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, shift-add during CALC, register the product on the last bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      acc_reg   <= '0;
      count_reg <= '0;
      neg_reg   <= 1'b0;
      m_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_sh_reg  <= {{WIDTH{1'b0}}, a_mag};
            b_sh_reg  <= b_mag;
            acc_reg   <= '0;
            count_reg <= '0;
            neg_reg   <= a_neg ^ b_neg;
          end
        end
        CALC: begin
          acc_reg   <= sum;
          a_sh_reg  <= a_sh_reg << 1;
          b_sh_reg  <= b_sh_reg >> 1;
          if (last_bit) begin
            m_reg     <= final_prod;
            count_reg <= '0;
          end else begin
            count_reg <= count_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign m         = m_reg;
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);

endmodule
